strand_loader: RTL

Downstream consumer of the strand counter's `load_on` window. For each strand it fetches `WORDS_PER_STRAND` packed 2-bit-per-base words from strand memory and presents the assembled strand to the correlator over a valid/ready handshake. On each accepted strand it returns a one-cycle `cor_ready` pulse to the counter, which advances the strand count.

---
 rtl/strand_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/strand_loader.sv
// strand_loader
//
// Fetches one strand of WORDS_PER_STRAND packed 2-bit-per-base words from
// strand memory each time the strand counter raises load_on. It then
// presents the assembled strand to the correlator over valid/ready. After
// each accepted strand it returns a single cor_ready pulse to the counter.
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   load_on       in   counter request for another strand (sampled in IDLE only)
//   base_addr     in   word address of strand 0
//   mem_rd_en     out  memory read strobe (1-cycle read latency)
//   mem_addr      out  word address of the current read
//   mem_rd_data   in   data for the read issued in the previous cycle
//   strand_data   out  assembled strand, word k at bits [32k+31:32k]
//   strand_valid  out  strand presented to the correlator
//   strand_ready  in   correlator accepts the strand
//   cor_ready     out  one-cycle pulse after each accepted strand
//   strand_idx    out  number of strands accepted since reset

module strand_loader #(
  parameter int WORDS_PER_STRAND = 4,
  parameter int ADDR_W           = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_on,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [31:0]                   mem_rd_data,
  output logic [32*WORDS_PER_STRAND-1:0] strand_data,
  output logic                          strand_valid,
  input  logic                          strand_ready,
  output logic                          cor_ready,
  output logic [31:0]                   strand_idx
);

  localparam int WC_W = (WORDS_PER_STRAND > 1) ? $clog2(WORDS_PER_STRAND) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_STRAND - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_SETTLE  = 3'd4
  } state_e;

  state_e                state_q,  state_d;
  logic [WC_W-1:0]       wc_q,     wc_d;
  logic                  rd_en_q,  rd_en_d;
  logic [ADDR_W-1:0]     addr_q,   addr_d;
  logic                  valid_q,  valid_d;
  logic                  cor_q,    cor_d;
  logic [31:0]           idx_q,    idx_d;
  logic                  settle_q, settle_d;

  // Read-return alignment: which slot the word arriving this cycle belongs to.
  logic                  rd_en_dly_q;
  logic [WC_W-1:0]       wc_dly_q;
  logic [WORDS_PER_STRAND-1:0][31:0] strand_q;

  logic [ADDR_W-1:0]     start_addr_s;

  // First word address of the next strand; the sum wraps modulo 2^ADDR_W.
  assign start_addr_s = base_addr + ADDR_W'(idx_q * 32'(WORDS_PER_STRAND));

  // Next-state and next-output decode for the fetch/present sequencer.
  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    rd_en_d  = 1'b0;
    addr_d   = {ADDR_W{1'b0}};
    valid_d  = 1'b0;
    cor_d    = 1'b0;
    idx_d    = idx_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (load_on) begin
          state_d = ST_FETCH;
          wc_d    = {WC_W{1'b0}};
          rd_en_d = 1'b1;
          addr_d  = start_addr_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Outputs are registered, so the read for wc_q+1 is set up here.
        if (wc_q == WC_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          wc_d    = wc_q + WC_W'(1);
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // Last word lands this cycle; presentation starts next cycle.
        state_d = ST_PRESENT;
        valid_d = 1'b1;
      end
      ST_PRESENT: begin
        if (valid_q && strand_ready) begin
          idx_d    = idx_q + 32'd1;
          cor_d    = 1'b1;
          settle_d = 1'b0;
          state_d  = ST_SETTLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Two cycles let the counter's registered load_on catch up, so a
        // stale request cannot start an extra fetch.
        if (settle_q) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wc_q     <= {WC_W{1'b0}};
      rd_en_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      valid_q  <= 1'b0;
      cor_q    <= 1'b0;
      idx_q    <= 32'd0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      cor_q    <= cor_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  // Capture each returned word into its slot one cycle after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_dly_q <= 1'b0;
      wc_dly_q    <= {WC_W{1'b0}};
      strand_q    <= '0;
    end else begin
      rd_en_dly_q <= rd_en_q;
      wc_dly_q    <= wc_q;
      if (rd_en_dly_q) begin
        strand_q[wc_dly_q] <= mem_rd_data;
      end
    end
  end

  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign strand_data  = strand_q;
  assign strand_valid = valid_q;
  assign cor_ready    = cor_q;
  assign strand_idx   = idx_q;

endmodule
